// File: rtl/mem_arbiter.sv
// Merges fetch and load/store requests onto one memory port and routes in-order
// memory responses back to their requester, dropping fetch data made stale by a flush.
module mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic                    i_if_req_valid,
  output logic                    o_if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_if_req_addr,
  output logic                    o_if_resp_valid,
  output logic [DATA_WIDTH-1:0]   o_if_resp_data,
  input  logic                    i_ls_req_valid,
  output logic                    o_ls_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_ls_req_addr,
  input  logic                    i_ls_req_we,
  input  logic [DATA_WIDTH-1:0]   i_ls_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_ls_req_wmask,
  output logic                    o_ls_resp_valid,
  output logic [DATA_WIDTH-1:0]   o_ls_resp_data,
  output logic                    o_mem_req_valid,
  input  logic                    i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   o_mem_req_addr,
  output logic                    o_mem_req_we,
  output logic [DATA_WIDTH-1:0]   o_mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_req_wmask,
  input  logic                    i_mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   i_mem_resp_data,
  input  logic [31:0]             i_log_fd
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic [SW-1:0]              starve_q, starve_d;
  logic [MAX_OUTSTANDING-1:0] src_q, src_d, we_q, we_d, kill_q, kill_d;
  logic                       if_resp_valid_q, if_resp_valid_d;
  logic                       ls_resp_valid_q, ls_resp_valid_d;
  logic [DATA_WIDTH-1:0]      if_resp_data_q, if_resp_data_d;
  logic [DATA_WIDTH-1:0]      ls_resp_data_q, ls_resp_data_d;

  logic full, starved, sel_if, push, pop, head_kill;

  always_comb begin
    full    = (count_q == CW'(MAX_OUTSTANDING));
    starved = (starve_q == SW'(STARVE_LIMIT));
    sel_if  = ~i_flush & (~i_ls_req_valid | (starved & i_if_req_valid));
  end

  assign o_mem_req_valid = ~full & (sel_if ? i_if_req_valid : i_ls_req_valid);
  assign o_if_req_ready  = sel_if & i_mem_req_ready & ~full;
  assign o_ls_req_ready  = ~sel_if & i_mem_req_ready & ~full;
  assign o_mem_req_addr  = sel_if ? i_if_req_addr : i_ls_req_addr;
  assign o_mem_req_we    = ~sel_if & i_ls_req_we;
  assign o_mem_req_wdata = sel_if ? '0 : i_ls_req_wdata;
  assign o_mem_req_wmask = sel_if ? '0 : i_ls_req_wmask;

  assign push      = o_mem_req_valid & i_mem_req_ready;
  assign pop       = i_mem_resp_valid & (count_q != '0);
  // A flush in the pop cycle kills the head too, so the response is dropped.
  assign head_kill = kill_q[rd_ptr_q] | i_flush;

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    src_d           = src_q;
    we_d            = we_q;
    kill_d          = kill_q;
    starve_d        = starve_q;
    if_resp_valid_d = 1'b0;
    ls_resp_valid_d = 1'b0;
    if_resp_data_d  = if_resp_data_q;
    ls_resp_data_d  = ls_resp_data_q;

    if (i_flush) kill_d = kill_q | ~src_q;

    if (push) begin
      src_d[wr_ptr_q]  = ~sel_if;
      we_d[wr_ptr_q]   = ~sel_if & i_ls_req_we;
      kill_d[wr_ptr_q] = 1'b0;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (src_q[rd_ptr_q]) begin
        ls_resp_valid_d = 1'b1;
        ls_resp_data_d  = we_q[rd_ptr_q] ? '0 : i_mem_resp_data;
      end else if (!head_kill) begin
        if_resp_valid_d = 1'b1;
        if_resp_data_d  = i_mem_resp_data;
      end
    end

    count_d = count_q + CW'(push) - CW'(pop);

    if (!i_if_req_valid || (push && sel_if)) starve_d = '0;
    else if (push && !sel_if && !starved)    starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      starve_q        <= '0;
      src_q           <= '0;
      we_q            <= '0;
      kill_q          <= '0;
      if_resp_valid_q <= 1'b0;
      ls_resp_valid_q <= 1'b0;
      if_resp_data_q  <= '0;
      ls_resp_data_q  <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      starve_q        <= starve_d;
      src_q           <= src_d;
      we_q            <= we_d;
      kill_q          <= kill_d;
      if_resp_valid_q <= if_resp_valid_d;
      ls_resp_valid_q <= ls_resp_valid_d;
      if_resp_data_q  <= if_resp_data_d;
      ls_resp_data_q  <= ls_resp_data_d;
    end
  end

  assign o_if_resp_valid = if_resp_valid_q;
  assign o_if_resp_data  = if_resp_data_q;
  assign o_ls_resp_valid = ls_resp_valid_q;
  assign o_ls_resp_data  = ls_resp_data_q;

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (i_rst_n && i_mem_resp_valid && count_q == '0)
      $display("mem_arbiter: memory response with nothing outstanding at %0t", $time);
  end
`endif

endmodule
